// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/ISSUE sequencer that owns the PC and latches the fetched word.
// Latency: instruction valid the cycle after imem_ack; minimum fetch-to-fetch period is 2 cycles.
// Backpressure: stall holds ISSUE (pc, instr, state frozen); memory wait holds FETCH at the same address.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/imem_addr        fetch request and byte address (address is always pc)
//   imem_ack/imem_rdata       memory response, sampled only in FETCH
//   stall                     downstream not ready, holds the issued instruction
//   branch/zero/branch_imm    conditional branch controls for the issued instruction
//   jump/jump_target          jump controls for the issued instruction (highest priority)
//   instr/opcode              latched instruction word and its opcode field
//   pc/pc_plus4               current pc and pc + 4
//   instr_valid               instr/opcode hold a valid instruction
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Target selection; jump outranks a taken branch. Low bits are cleared so
  // the pc stays word aligned regardless of the selected source.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
    next_pc[1:0] = 2'b00;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Acks arriving here are stray and are dropped.
        if (!stall) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Gated by rst so no request or valid instruction is presented while the
  // reset is pending, even before the registers have been cleared.
  assign imem_req    = (state_q == FETCH) && !rst;
  assign instr_valid = (state_q == ISSUE) && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];

endmodule
